// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader_pkg
// Description : Shared loader state encoding and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_ERR  = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam int          LEN_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader_if
// Description : Boot byte stream (valid/ready) plus CPU instruction fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_loader_if;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_read;

    modport master (
        output load_valid, load_byte, inst_mem_addr,
        input  load_ready, inst_mem_read
    );

    modport slave (
        input  load_valid, load_byte, inst_mem_addr,
        output load_ready, inst_mem_read
    );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs four little-endian bytes into a word; strobes on the 4th.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler
    import inst_mem_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clear,
    input  wire logic        byte_en,
    input  wire logic [7:0]  byte_in,
    output logic      [31:0] word_out,
    output logic             word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_low;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (byte_en) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // The top byte is never stored: it is taken straight from byte_in.
    always_ff @(posedge clk) begin
        if (byte_en) begin
            case (r_cnt)
                2'd0:    r_low[7:0]   <= byte_in;
                2'd1:    r_low[15:8]  <= byte_in;
                2'd2:    r_low[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    assign word_out   = {byte_in, r_low};
    assign word_valid = byte_en && (r_cnt == 2'(LEN_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Boot-loads instruction memory from a byte stream, then serves
//               CPU fetches. Optional checksum: INST_MEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
)(
    input  wire logic         clk,
    input  wire logic         rst,
    inst_mem_loader_if.slave  bus,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_overflow,
    output logic              load_error
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_n;
    logic [31:0] w_n_next;
    logic [31:0] r_idx;
    logic        r_cpu_rst;
    logic        r_overflow;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_active;
    logic        w_fire;
    logic        w_asm_en;
    logic        w_asm_clear;
    logic [31:0] w_word;
    logic        w_word_valid;
    logic        w_last_word;
    logic        w_idx_in_range;
    logic        w_data_word;
    logic [IDX_W-1:0] w_rd_idx;
    logic        w_rd_hi_zero;
    logic        w_unused_addr;

    assign w_active       = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign bus.load_ready = w_active && !rst;
    assign w_fire         = bus.load_valid && bus.load_ready;
    assign w_asm_en       = w_fire && ((r_state == ST_LEN) || (r_state == ST_DATA));
    assign w_asm_clear    = !((r_state == ST_LEN) || (r_state == ST_DATA));

    byte_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_asm_clear),
        .byte_en    (w_asm_en),
        .byte_in    (bus.load_byte),
        .word_out   (w_word),
        .word_valid (w_word_valid)
    );

    assign w_data_word    = (r_state == ST_DATA) && w_word_valid;
    assign w_last_word    = (r_idx + 32'd1) == r_n;
    assign w_idx_in_range = r_idx < 32'(DEPTH_WORDS);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    localparam state_t c_after_load = ST_CSUM;

    logic [7:0] r_sum;
    logic [7:0] w_sum_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_fire && (r_state == ST_DATA)) begin
            r_sum <= r_sum + bus.load_byte;
        end
    end

    assign w_sum_total = r_sum + bus.load_byte;
    assign load_error  = (r_state == ST_ERR);
`else
    localparam state_t c_after_load = ST_RUN;

    assign load_error = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_n_next     = r_n;
        case (r_state)
            ST_LEN: begin
                if (w_word_valid) begin
                    w_n_next     = w_word;
                    w_state_next = (w_word == 32'd0) ? c_after_load : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_valid && w_last_word) begin
                    w_state_next = c_after_load;
                end
            end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_fire) begin
                    w_state_next = (w_sum_total == 8'd0) ? ST_RUN : ST_ERR;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LEN;
            r_n        <= '0;
            r_idx      <= '0;
            r_cpu_rst  <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_n       <= w_n_next;
            // CPU leaves reset on the very edge that enters RUN.
            r_cpu_rst <= (w_state_next != ST_RUN);
            if (w_data_word) begin
                r_idx <= r_idx + 32'd1;
                if (!w_idx_in_range) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Array is deliberately left out of reset so a reload only overwrites.
    always_ff @(posedge clk) begin
        if (w_data_word && w_idx_in_range) begin
            r_mem[r_idx[IDX_W-1:0]] <= w_word;
        end
    end

    assign w_rd_idx      = bus.inst_mem_addr[IDX_W+1:2];
    assign w_rd_hi_zero  = (bus.inst_mem_addr[31:IDX_W+2] == '0);
    assign w_unused_addr = ^bus.inst_mem_addr[1:0];

    assign bus.inst_mem_read = ((r_state == ST_RUN) && w_rd_hi_zero) ? r_mem[w_rd_idx] : NOP_INST;

    assign cpu_rst       = r_cpu_rst;
    assign load_done     = (r_state == ST_RUN);
    assign load_overflow = r_overflow;

endmodule
`default_nettype wire
